// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, instruction
// field positions and operand-usage decode.
package alu_pkg;

    typedef enum logic [3:0] {
        FN_ADD   = 4'd0,
        FN_SUB   = 4'd1,
        FN_AND   = 4'd2,
        FN_NOT   = 4'd3,
        FN_PASSB = 4'd4,
        FN_OR    = 4'd5,
        FN_XOR   = 4'd6,
        FN_SLT   = 4'd7,
        FN_LD    = 4'd8,
        FN_ST    = 4'd9,
        FN_SHR   = 4'd10,
        FN_SHL   = 4'd11,
        FN_HALT  = 4'd15
    } func_e;

    localparam int INSTR_W  = 24;
    localparam int FUNC_LSB = 20;
    localparam int RD_LSB   = 16;
    localparam int RS1_LSB  = 12;
    localparam int RS2_LSB  = 8;
    localparam int ADDR_LSB = 0;

    function automatic logic uses_rs1(input logic [3:0] func);
        case (func)
            FN_ADD, FN_SUB, FN_AND, FN_NOT, FN_OR, FN_XOR,
            FN_SLT, FN_LD, FN_SHR, FN_SHL: uses_rs1 = 1'b1;
            default:                       uses_rs1 = 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [3:0] func);
        case (func)
            FN_ADD, FN_SUB, FN_AND, FN_PASSB,
            FN_OR, FN_XOR, FN_SLT, FN_ST: uses_rs2 = 1'b1;
            default:                      uses_rs2 = 1'b0;
        endcase
    endfunction

    // Opcodes 12..14 are reserved and never reach the pipeline.
    function automatic logic is_illegal(input logic [3:0] func);
        is_illegal = (func >= 4'd12) && (func <= 4'd14);
    endfunction

endpackage

// File: rtl/alu_hazard_sb.sv
// Destination-register scoreboard for the most recent issue slots; flags a
// read-after-write hazard for the instruction currently being decoded.
module alu_hazard_sb #(
    parameter int HAZARD_WINDOW = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       shift,
    input  logic       ins_valid,
    input  logic [3:0] ins_rd,
    input  logic [3:0] rs1,
    input  logic [3:0] rs2,
    input  logic       use_rs1,
    input  logic       use_rs2,
    output logic       stall
);

    logic [HAZARD_WINDOW-1:0]      valid_r;
    logic [HAZARD_WINDOW-1:0][3:0] rd_r;

    // Slot 0 holds the newest issue slot; bubbles enter as invalid.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            valid_r <= '0;
            rd_r    <= '0;
        end else if (shift) begin
            valid_r[0] <= ins_valid;
            rd_r[0]    <= ins_valid ? ins_rd : 4'd0;
            for (int i = 1; i < HAZARD_WINDOW; i++) begin
                valid_r[i] <= valid_r[i-1];
                rd_r[i]    <= rd_r[i-1];
            end
        end
    end

    // Compare each used source against every live destination.
    always_comb begin
        stall = 1'b0;
        for (int i = 0; i < HAZARD_WINDOW; i++) begin
            stall = stall | (valid_r[i] &&
                             ((use_rs1 && (rs1 == rd_r[i])) ||
                              (use_rs2 && (rs2 == rd_r[i]))));
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequencer that fetches packed ALU instructions from a local program store
// and issues them to the pipeline, inserting bubbles on RAW hazards.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int PROG_DEPTH    = 64,
    parameter int HAZARD_WINDOW = 2,
    parameter int DRAIN_CYCLES  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          prog_we,
    input  logic [$clog2(PROG_DEPTH)-1:0] prog_waddr,
    input  logic [INSTR_W-1:0]            prog_wdata,
    input  logic                          start,
    output logic [3:0]                    rs1,
    output logic [3:0]                    rs2,
    output logic [3:0]                    rd,
    output logic [3:0]                    func,
    output logic [7:0]                    addr,
    output logic                          issue_valid,
    output logic                          busy,
    output logic                          done,
    output logic                          illegal_err,
    output logic                          wrap_err,
    output logic [15:0]                   issued_count,
    output logic [15:0]                   stall_count
);

    localparam int AW = $clog2(PROG_DEPTH);
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [INSTR_W-1:0] mem [PROG_DEPTH];
    logic [INSTR_W-1:0] rdata_r;
    logic [1:0]         state_r, state_nxt_s;
    logic [AW-1:0]      pc_r, pc_nxt_s;
    logic [DW-1:0]      drain_cnt_r;
    logic [3:0]         cur_func_s, cur_rd_s, cur_rs1_s, cur_rs2_s;
    logic [7:0]         cur_addr_s;
    logic               decode_s, halt_s, illegal_s, issue_s, stall_s;
    logic               hazard_s, last_s, wrap_s, drain_end_s;

    alu_hazard_sb #(
        .HAZARD_WINDOW(HAZARD_WINDOW)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .clr      (state_r == ST_IDLE),
        .shift    (state_r != ST_IDLE),
        .ins_valid(issue_s),
        .ins_rd   (cur_rd_s),
        .rs1      (cur_rs1_s),
        .rs2      (cur_rs2_s),
        .use_rs1  (uses_rs1(cur_func_s)),
        .use_rs2  (uses_rs2(cur_func_s)),
        .stall    (hazard_s)
    );

    // rdata_r always mirrors mem[pc_r]: the read address is the next pc, so
    // entry 0 is already on the read port in FETCH and decodes there.
    always_ff @(posedge clk) begin
        if (prog_we && (state_r == ST_IDLE)) begin
            mem[prog_waddr] <= prog_wdata;
        end
        rdata_r <= mem[pc_nxt_s];
    end

    // Decode of the word at pc, next-pc and next-state selection.
    always_comb begin
        cur_func_s  = rdata_r[FUNC_LSB +: 4];
        cur_rd_s    = rdata_r[RD_LSB +: 4];
        cur_rs1_s   = rdata_r[RS1_LSB +: 4];
        cur_rs2_s   = rdata_r[RS2_LSB +: 4];
        cur_addr_s  = rdata_r[ADDR_LSB +: 8];
        decode_s    = (state_r == ST_FETCH) || (state_r == ST_ISSUE);
        halt_s      = decode_s && (cur_func_s == FN_HALT);
        illegal_s   = decode_s && is_illegal(cur_func_s);
        issue_s     = decode_s && !halt_s && !illegal_s && !hazard_s;
        stall_s     = decode_s && !halt_s && !illegal_s && hazard_s;
        last_s      = (pc_r == AW'(PROG_DEPTH - 1));
        wrap_s      = (issue_s || illegal_s) && last_s;
        drain_end_s = (state_r == ST_DRAIN) && (drain_cnt_r == DW'(DRAIN_CYCLES - 1));
        pc_nxt_s    = pc_r;
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                pc_nxt_s = AW'(0);
                if (start) state_nxt_s = ST_FETCH;
                else       state_nxt_s = ST_IDLE;
            end
            ST_FETCH, ST_ISSUE: begin
                if (halt_s || wrap_s) state_nxt_s = ST_DRAIN;
                else                  state_nxt_s = ST_ISSUE;
                if ((issue_s || illegal_s) && !last_s) pc_nxt_s = pc_r + AW'(1);
                else                                   pc_nxt_s = pc_r;
            end
            ST_DRAIN: begin
                pc_nxt_s = AW'(0);
                if (drain_end_s) state_nxt_s = ST_IDLE;
                else             state_nxt_s = ST_DRAIN;
            end
            default: begin
                pc_nxt_s    = AW'(0);
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Control state, registered pipeline outputs, status and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            pc_r         <= AW'(0);
            drain_cnt_r  <= DW'(0);
            rs1          <= 4'd0;
            rs2          <= 4'd0;
            rd           <= 4'd0;
            func         <= 4'd0;
            addr         <= 8'd0;
            issue_valid  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            illegal_err  <= 1'b0;
            wrap_err     <= 1'b0;
            issued_count <= 16'd0;
            stall_count  <= 16'd0;
        end else begin
            state_r     <= state_nxt_s;
            pc_r        <= pc_nxt_s;
            drain_cnt_r <= (state_r == ST_DRAIN) ? drain_cnt_r + DW'(1) : DW'(0);
            issue_valid <= issue_s;
            done        <= drain_end_s;
            if (issue_s) begin
                rs1  <= cur_rs1_s;
                rs2  <= cur_rs2_s;
                rd   <= cur_rd_s;
                func <= cur_func_s;
                addr <= cur_addr_s;
            end
            if ((state_r == ST_IDLE) && start) begin
                busy         <= 1'b1;
                illegal_err  <= 1'b0;
                wrap_err     <= 1'b0;
                issued_count <= 16'd0;
                stall_count  <= 16'd0;
            end else begin
                if (drain_end_s) busy <= 1'b0;
                if (illegal_s)   illegal_err <= 1'b1;
                if (wrap_s)      wrap_err <= 1'b1;
                if (issue_s && (issued_count != 16'hFFFF)) issued_count <= issued_count + 16'd1;
                if (stall_s && (stall_count != 16'hFFFF))  stall_count <= stall_count + 16'd1;
            end
        end
    end

endmodule
